// File: rtl/bsg_clk_gen_pearl_div_array.sv
// Multi-channel glitch-free programmable clock divider.
// Config is staged per channel and applied only at period boundaries.
module bsg_clk_gen_pearl_div_array #(
  parameter int num_ch_p   = 4,
  parameter int ds_width_p = 8,
  localparam int ch_w_lp   = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  cfg_v_i,
  input  logic [ch_w_lp-1:0]    cfg_ch_i,
  input  logic [ds_width_p-1:0] cfg_ds_i,
  input  logic                  cfg_en_i,
  input  logic                  async_output_disable_i,
  output logic [num_ch_p-1:0]   clk_o,
  output logic [num_ch_p-1:0]   pending_o
);

  logic dis_s1_q;
  logic dis_s_q;

  // Reset to disabled so nothing toggles before the first real sample.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dis_s1_q <= 1'b1;
      dis_s_q  <= 1'b1;
    end else begin
      dis_s1_q <= async_output_disable_i;
      dis_s_q  <= dis_s1_q;
    end
  end

  for (genvar i = 0; i < num_ch_p; i++) begin : g_ch
    logic [ds_width_p-1:0] cnt_q, cnt_d;
    logic [ds_width_p-1:0] ds_q, ds_d;
    logic [ds_width_p-1:0] pds_q, pds_d;
    logic                  out_q, out_d;
    logic                  en_q, en_d;
    logic                  pen_q, pen_d;
    logic                  pv_q, pv_d;
    logic                  run;
    logic                  tc;
    logic                  bnd;
    logic                  wr;

    assign run = en_q & ~dis_s_q;
    assign tc  = (cnt_q == ds_q);
    assign bnd = (out_q & tc) | (~out_q & ~run);
    assign wr  = cfg_v_i && (cfg_ch_i == ch_w_lp'(i));

    always_comb begin
      cnt_d = cnt_q;
      out_d = out_q;
      ds_d  = ds_q;
      en_d  = en_q;
      pds_d = pds_q;
      pen_d = pen_q;
      pv_d  = pv_q;
      if (bnd && pv_q) begin
        ds_d  = pds_q;
        en_d  = pen_q;
        pv_d  = 1'b0;
        cnt_d = '0;
        out_d = 1'b0;
      end else if (out_q || run) begin
        // High phase always runs to completion, even if run drops.
        if (tc) begin
          cnt_d = '0;
          out_d = ~out_q;
        end else begin
          cnt_d = cnt_q + ds_width_p'(1);
        end
      end else begin
        cnt_d = '0;
        out_d = 1'b0;
      end
      if (wr) begin
        pds_d = cfg_ds_i;
        pen_d = cfg_en_i;
        pv_d  = 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cnt_q <= '0;
        out_q <= 1'b0;
        ds_q  <= '0;
        en_q  <= 1'b0;
        pds_q <= '0;
        pen_q <= 1'b0;
        pv_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        out_q <= out_d;
        ds_q  <= ds_d;
        en_q  <= en_d;
        pds_q <= pds_d;
        pen_q <= pen_d;
        pv_q  <= pv_d;
      end
    end

    assign clk_o[i]     = out_q;
    assign pending_o[i] = pv_q;
  end

endmodule

// File: tb/tb_bsg_clk_gen_pearl_div_array.sv
// Bench for bsg_clk_gen_pearl_div_array: directed plus random
// config traffic against a phase/age reference model.
module tb_bsg_clk_gen_pearl_div_array;

  localparam int NCH = 5;
  localparam int DSW = 4;
  localparam int CHW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n_i;
  logic           cfg_v_i;
  logic [CHW-1:0] cfg_ch_i;
  logic [DSW-1:0] cfg_ds_i;
  logic           cfg_en_i;
  logic           dis_i;
  logic [NCH-1:0] clk_o;
  logic [NCH-1:0] pending_o;

  bsg_clk_gen_pearl_div_array #(
    .num_ch_p  (NCH),
    .ds_width_p(DSW)
  ) dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n_i),
    .cfg_v_i               (cfg_v_i),
    .cfg_ch_i              (cfg_ch_i),
    .cfg_ds_i              (cfg_ds_i),
    .cfg_en_i              (cfg_en_i),
    .async_output_disable_i(dis_i),
    .clk_o                 (clk_o),
    .pending_o             (pending_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: each channel is either in its high phase or not,
  // and a phase lasts ds+1 cycles counted by age.
  bit m_hi [NCH];
  int m_age[NCH];
  int m_ds [NCH];
  bit m_en [NCH];
  int p_ds [NCH];
  bit p_en [NCH];
  bit p_v  [NCH];
  bit sync1, sync2;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_hi[i] = 0; m_age[i] = 0; m_ds[i] = 0; m_en[i] = 0;
      p_ds[i] = 0; p_en[i] = 0; p_v[i] = 0;
    end
    sync1 = 1; sync2 = 1;
  endfunction

  function automatic void model_step();
    bit dis;
    dis = sync2;
    for (int i = 0; i < NCH; i++) begin
      bit run, last, bnd;
      run  = m_en[i] && !dis;
      last = (m_age[i] == m_ds[i]);
      bnd  = m_hi[i] ? last : !run;
      if (bnd && p_v[i]) begin
        m_ds[i] = p_ds[i]; m_en[i] = p_en[i]; p_v[i] = 0;
        m_hi[i] = 0; m_age[i] = 0;
      end else if (m_hi[i] || run) begin
        if (last) begin
          m_hi[i] = !m_hi[i]; m_age[i] = 0;
        end else begin
          m_age[i]++;
        end
      end else begin
        m_age[i] = 0;
      end
    end
    if (cfg_v_i && int'(cfg_ch_i) < NCH) begin
      p_ds[cfg_ch_i] = int'(cfg_ds_i);
      p_en[cfg_ch_i] = cfg_en_i;
      p_v[cfg_ch_i]  = 1;
    end
    sync2 = sync1;
    sync1 = dis_i;
  endfunction

  function automatic logic [NCH-1:0] exp_clk();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = m_hi[i];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_pend();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = p_v[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset_n_i) model_step();
      else model_reset();
      #1;
      chk("clk_o", 32'(clk_o), 32'(exp_clk()));
      chk("pending_o", 32'(pending_o), 32'(exp_pend()));
    end
  endtask

  task automatic wr(input int ch, input int ds, input int en);
    cfg_v_i  = 1'b1;
    cfg_ch_i = CHW'(ch);
    cfg_ds_i = DSW'(ds);
    cfg_en_i = en[0];
    tick(1);
    cfg_v_i  = 1'b0;
  endtask

  initial begin
    reset_n_i = 1'b0;
    cfg_v_i   = 1'b0;
    cfg_ch_i  = '0;
    cfg_ds_i  = '0;
    cfg_en_i  = 1'b0;
    dis_i     = 1'b0;
    model_reset();
    #1;
    chk("reset_clk", 32'(clk_o), 32'd0);
    chk("reset_pend", 32'(pending_o), 32'd0);
    tick(3);
    reset_n_i = 1'b1;
    tick(3);

    // ds=0 on ch0: pending for one cycle, first rise two cycles later
    wr(0, 0, 1);
    chk("ch0_pend_t1", 32'(pending_o[0]), 32'd1);
    tick(1);
    chk("ch0_pend_t2", 32'(pending_o[0]), 32'd0);
    chk("ch0_clk_t2", 32'(clk_o[0]), 32'd0);
    tick(1);
    chk("ch0_clk_t3", 32'(clk_o[0]), 32'd1);
    tick(1);
    chk("ch0_clk_t4", 32'(clk_o[0]), 32'd0);
    tick(1);
    chk("ch0_clk_t5", 32'(clk_o[0]), 32'd1);

    wr(1, 3, 1);
    tick(30);
    for (int k = 0; k < 64 && !(m_hi[1] && m_age[1] == 0); k++) tick(1);
    tick(1);
    wr(1, 1, 1);
    tick(20);
    for (int k = 0; k < 64 && !m_hi[1]; k++) tick(1);
    wr(1, 1, 0);
    tick(12);
    wr(2, 2, 1);
    tick(10);
    for (int k = 0; k < 64 && !(m_en[2] && !m_hi[2]); k++) tick(1);
    wr(2, 0, 0);
    tick(20);

    wr(0, 0, 1);
    wr(1, 1, 1);
    wr(2, 2, 1);
    wr(3, 5, 1);
    tick(30);
    dis_i = 1'b1;
    tick(20);
    chk("dis_all_low", 32'(clk_o), 32'd0);
    dis_i = 1'b0;
    tick(30);

    for (int k = 0; k < 64 && !m_hi[3]; k++) tick(1);
    tick(2);
    wr(0, 7, 1);
    reset_n_i = 1'b0;
    #1;
    chk("async_rst_clk", 32'(clk_o), 32'd0);
    chk("async_rst_pend", 32'(pending_o), 32'd0);
    model_reset();
    tick(3);
    reset_n_i = 1'b1;
    tick(10);
    wr(5, 2, 1);
    wr(6, 0, 1);
    wr(7, 3, 1);
    tick(6);
    chk("bad_ch_clk", 32'(clk_o), 32'd0);
    chk("bad_ch_pend", 32'(pending_o), 32'd0);

    for (int k = 0; k < 600; k++) begin
      cfg_v_i  = ($urandom % 3) == 0;
      cfg_ch_i = CHW'($urandom % 8);
      cfg_ds_i = DSW'($urandom);
      cfg_en_i = ($urandom % 4) != 0;
      if (($urandom % 40) == 0) dis_i = ~dis_i;
      tick(1);
    end
    cfg_v_i = 1'b0;
    dis_i   = 1'b0;
    tick(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
